// File: rtl/breakout_pkg.sv
// Shared types for the I2C arbiter: the requester descriptor layout and the FSM state encoding.
package breakout_pkg;

  localparam int DESC_W = 24;

  // Bit layout MSB..LSB: dev_addr[23:17], rw[16], reg_addr[15:8], wdata[7:0].
  typedef struct packed {
    logic [6:0] dev_addr;
    logic       rw;
    logic [7:0] reg_addr;
    logic [7:0] wdata;
  } desc_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    WAIT  = 3'd2,
    RESP  = 3'd3,
    GAP   = 3'd4
  } arb_state_e;

endpackage

// File: rtl/i2c_arbiter_if.sv
// Requester-side and master-side signals of the I2C arbiter.
// The slave modport is the arbiter; the master modport is whoever drives requests and the I2C master status.
interface i2c_arbiter_if #(
  parameter int NUM_REQ = 4
) ();

  logic [NUM_REQ-1:0]                      i_req;
  logic [NUM_REQ*breakout_pkg::DESC_W-1:0] i_desc;
  logic [NUM_REQ-1:0]                      o_ack;
  logic [7:0]                              o_rdata;
  logic                                    o_err;
  logic [NUM_REQ-1:0]                      o_grant;
  logic                                    o_m_start;
  logic [breakout_pkg::DESC_W-1:0]         o_m_desc;
  logic                                    i_m_done;
  logic                                    i_m_nack;
  logic [7:0]                              i_m_rdata;

  modport slave (
    input  i_req, i_desc, i_m_done, i_m_nack, i_m_rdata,
    output o_ack, o_rdata, o_err, o_grant, o_m_start, o_m_desc
  );

  modport master (
    output i_req, i_desc, i_m_done, i_m_nack, i_m_rdata,
    input  o_ack, o_rdata, o_err, o_grant, o_m_start, o_m_desc
  );

endinterface

// File: rtl/rr_select.sv
// Combinational round-robin picker: one-hot winner, searching upward from the bit above ptr_i and wrapping.
module rr_select #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] onehot_o
);

  logic             found;
  logic [IDX_W-1:0] idx;

  always_comb begin
    onehot_o = '0;
    found    = 1'b0;
    idx      = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = IDX_W'((int'(ptr_i) + i) % NUM_REQ);
      if (!found && req_i[idx]) begin
        onehot_o[idx] = 1'b1;
        found         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_arbiter.sv
// Shares one I2C master among NUM_REQ requesters, round-robin, one transaction at a time with a bus-free gap.
// Request to o_m_start is 2 cycles on an idle bus; WAIT ends on i_m_done or after TIMEOUT_CLKS cycles.
module i2c_arbiter
  import breakout_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int CLK_RATE_HZ  = 60_000_000,
  parameter int TIMEOUT_CLKS = 60_000,
  parameter int GAP_CLKS     = 150
) (
  input  logic          i_clk,
  input  logic          i_reset,
  i2c_arbiter_if.slave  bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TMO_W = $clog2(TIMEOUT_CLKS);
  localparam int GAP_W = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;

  localparam logic [IDX_W-1:0] PTR_RST  = IDX_W'(NUM_REQ - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CLKS - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CLKS - 1);

  if (TIMEOUT_CLKS < 2 || GAP_CLKS < 1 || CLK_RATE_HZ < 1) begin : g_bad_params
    $error("i2c_arbiter: needs TIMEOUT_CLKS>=2, GAP_CLKS>=1, CLK_RATE_HZ>=1");
  end

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  desc_t              desc_q, desc_d;
  logic [7:0]         rdata_q, rdata_d;
  logic               err_q, err_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [GAP_W-1:0]   gap_q, gap_d;

  logic [NUM_REQ-1:0] win;
  logic [IDX_W-1:0]   win_idx;
  desc_t              win_desc;

  rr_select #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_select (
    .req_i    (bus.i_req),
    .ptr_i    (ptr_q),
    .onehot_o (win)
  );

  always_comb begin
    win_idx  = '0;
    win_desc = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win[i]) begin
        win_idx  = IDX_W'(i);
        win_desc = bus.i_desc[i*DESC_W +: DESC_W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    grant_d = grant_q;
    desc_d  = desc_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    tmo_d   = tmo_q;
    gap_d   = gap_q;

    case (state_q)
      IDLE: begin
        if (|bus.i_req) begin
          grant_d = win;
          owner_d = win_idx;
          desc_d  = win_desc;
          state_d = START;
        end
      end
      START: begin
        tmo_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // A completion arriving on the timeout cycle still wins.
        if (bus.i_m_done) begin
          rdata_d = bus.i_m_rdata;
          err_d   = bus.i_m_nack;
          state_d = RESP;
        end else if (tmo_q == TMO_LAST) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      RESP: begin
        ptr_d   = owner_q;
        grant_d = '0;
        gap_d   = '0;
        state_d = GAP;
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= IDLE;
      ptr_q   <= PTR_RST;
      owner_q <= '0;
      grant_q <= '0;
      desc_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      tmo_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      grant_q <= grant_d;
      desc_q  <= desc_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
      gap_q   <= gap_d;
    end
  end

  assign bus.o_m_start = (state_q == START);
  assign bus.o_m_desc  = desc_q;
  assign bus.o_grant   = grant_q;
  assign bus.o_ack     = (state_q == RESP) ? grant_q : '0;
  assign bus.o_rdata   = (state_q == RESP) ? rdata_q : '0;
  assign bus.o_err     = (state_q == RESP) ? err_q   : 1'b0;

endmodule

// File: doc/i2c_arbiter.md
I2C_ARBITER -- requirements
Module: i2c_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing the I2C master.
REQ-002 Parameter CLK_RATE_HZ, default 60_000_000: sys_clk rate.
REQ-003 Parameter TIMEOUT_CLKS, default 60_000: max transaction length (1 ms at 60 MHz).
REQ-004 Parameter GAP_CLKS, default 150: bus-free holdoff between transactions.
REQ-005 i_clk  in  1  sys_clk; single clock domain.
REQ-006 i_reset  in  1  asynchronous, active-low reset.
REQ-007 i_req  in  NUM_REQ  per-requester transaction request level.
REQ-008 i_desc  in  NUM_REQ*24  per-requester descriptor {dev_addr[6:0], rw, reg[7:0], wdata[7:0]}.
REQ-009 o_ack  out  NUM_REQ  one-cycle completion pulse to the granted requester.
REQ-010 o_rdata  out  8  read data, valid in the o_ack cycle.
REQ-011 o_err  out  1  error flag, valid in the o_ack cycle (NACK or timeout).
REQ-012 o_grant  out  NUM_REQ  one-hot current owner, zero when idle.
REQ-013 o_m_start  out  1  one-cycle start strobe to the I2C master.
REQ-014 o_m_desc  out  24  latched descriptor to the master, stable from start until done.
REQ-015 i_m_done  in  1  master completion pulse.
REQ-016 i_m_nack  in  1  master NACK status, sampled with i_m_done.
REQ-017 i_m_rdata  in  8  master read byte, sampled with i_m_done.

Function
REQ-018 The FSM SHALL use the states IDLE, START, WAIT, RESP and GAP.
REQ-019 IDLE: with any i_req bit set, the block SHALL select a winner round-robin, starting from the bit above the last winner, latch its descriptor and one-hot grant, and enter START on the next edge.
REQ-020 START: o_m_start SHALL be high for exactly one cycle, then the FSM SHALL enter WAIT.
REQ-021 WAIT: on i_m_done the block SHALL capture i_m_rdata and i_m_nack and enter RESP; a timeout counter reaching TIMEOUT_CLKS-1 SHALL enter RESP with the error flag set and rdata=0.
REQ-022 RESP: o_ack[owner], o_rdata and o_err SHALL be valid for exactly one cycle; the round-robin pointer SHALL update to the owner; the FSM SHALL then enter GAP.
REQ-023 GAP: o_grant SHALL be zero for GAP_CLKS cycles, then the FSM SHALL return to IDLE.
REQ-024 Latency from i_req rising (idle bus) to o_m_start SHALL be 2 cycles.
REQ-025 A requester SHALL hold i_req until its o_ack; deasserting before grant withdraws the request; deasserting after grant SHALL NOT abort the transaction.
REQ-026 Descriptor changes after grant SHALL NOT affect o_m_desc.
REQ-027 Simultaneous requests SHALL be served one per transaction, with no requester served twice while another is pending.
REQ-028 The round-robin pointer SHALL wrap from NUM_REQ-1 to 0.
REQ-029 i_m_done outside WAIT SHALL be ignored.
REQ-030 i_m_done in the same cycle as the timeout SHALL be treated as a completion: no error, data captured.
REQ-031 The timeout counter SHALL be sized $clog2(TIMEOUT_CLKS) and cleared on entry to WAIT.

Reset
REQ-032 While i_reset is low, the block SHALL be in IDLE with o_ack, o_grant, o_m_start, o_err and o_rdata at 0, o_m_desc at 0, and the pointer at requester NUM_REQ-1, so requester 0 has priority first.
REQ-033 Reset mid-transaction SHALL abandon it without issuing o_ack; the requester re-requests.

Structure
REQ-034 The descriptor field widths/offsets and the FSM state encoding SHALL live in the shared package breakout_pkg.
REQ-035 The round-robin selection SHALL be a sub-module rr_select (inputs req and pointer, output one-hot), purely combinational.

Verification
REQ-036 Single requester: i_req=0001, desc={0x20,0,0x12,0xAB}, done after 50 cycles -> o_m_start at cycle 2, o_m_desc=0x40_12_AB, o_ack=0001 with o_err=0.
REQ-037 All four requesting continuously from reset -> grants in the order 0,1,2,3,0, each separated by at least GAP_CLKS of zero o_grant.
REQ-038 Master never completes -> o_ack with o_err=1 and o_rdata=0 exactly TIMEOUT_CLKS cycles after WAIT entry.
REQ-039 i_m_nack=1 with done on a read -> o_err=1, and the pointer still advances.
REQ-040 Reset low during WAIT, then release -> no o_ack; a re-request is served with requester 0 priority.
REQ-041 Requester 2 drops i_req after grant and i_desc changes -> the transaction completes with the original descriptor and o_ack=0100.
